clint: RTL
==========

Name: clint

Overview:
- Core-local interruptor holding the 64-bit mtime and mtimecmp registers and the msip register.
- Sits directly downstream of the core on its memory request interface as a memory-mapped slave.
- Produces the core's timer_interrupt and software_interrupt inputs.
- The interconnect routes requests to it only when the address falls in its window.

Parameters:
- BASE_ADDRESS, 32'h0200_0000, byte base of the 64 KiB register window.
- PRESCALE, 1, clk cycles per mtime increment; legal range is 1 and above.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- memory_enable  input  1  request strobe from the core.
- memory_command  input  1  request kind: 1 = write, 0 = read.
- read_memory_address  input  32  byte address for reads.
- write_memory_address  input  32  byte address for writes.
- write_memory_data  input  32  write data.
- write_memory_mask  input  32  per-bit write enable; bit=1 updates that bit.
- memory_ready  output  1  block can accept a request this cycle.
- memory_valid  output  1  one-cycle completion pulse; qualifies read_memory_data.
- read_memory_data  output  32  read result, 0 when memory_valid is low.
- timer_interrupt  output  1  registered (mtime >= mtimecmp), unsigned 64-bit compare.
- software_interrupt  output  1  msip bit 0.

Behaviour:
- Register map, offsets from BASE_ADDRESS:
  - 0x0000 msip: bit 0 only, other bits read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other offset inside the window reads 0; writes to it are ignored but still complete.
- Offset = address[15:0]; address[1:0] is ignored (word access only).
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0.
  - State IDLE, prescale counter = 0.
  - memory_ready = 1, memory_valid = 0, read_memory_data = 0.
  - timer_interrupt = 0, software_interrupt = 0.
- FSM has two states:
  - IDLE: memory_ready = 1. If memory_enable is high, the request is accepted that cycle → RESPOND.
  - RESPOND: memory_ready = 0, memory_valid = 1 for exactly one cycle → IDLE.
- Latency and throughput:
  - Request accepted in cycle N; memory_valid high in N+1; memory_ready high again in N+2.
  - Maximum rate is one request per 2 cycles.
  - memory_enable is ignored while in RESPOND.
- Reads:
  - Use read_memory_address.
  - Return the register value sampled in the acceptance cycle N, before any same-cycle increment.
- Writes:
  - Use write_memory_address.
  - Effect: new = (old & ~mask) | (data & mask), applied at the end of cycle N.
  - Visible to reads accepted from N+1 onward.
  - memory_valid also pulses for writes, with read_memory_data = 0.
- Prescaler:
  - Counter runs 0..PRESCALE-1 and emits a tick when it equals PRESCALE-1.
  - On a tick, mtime increments by 1 across all 64 bits, with carry from low to high word.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Simultaneous write to an mtime half and a tick:
  - The write wins for the whole of mtime; no increment that cycle.
  - The prescale counter keeps running.
- Interrupt timing:
  - timer_interrupt is computed from the register values at the end of each cycle.
  - It is visible one cycle after mtime or mtimecmp changes.
  - Interrupts are level outputs, cleared only by register changes; there is no acknowledge.
- Reset mid-operation: an in-flight RESPOND is dropped; memory_valid is 0 in the cycle after reset is asserted.

Decomposition:
- clint_pkg holds:
  - Offset constants MSIP_OFFSET, MTIMECMP_LO_OFFSET, MTIMECMP_HI_OFFSET, MTIME_LO_OFFSET, MTIME_HI_OFFSET.
  - clint_state_t enum {IDLE, RESPOND}.
  - MEMORY_COMMAND_READ and MEMORY_COMMAND_WRITE constants.
- One sub-module, tick_divider (parameter PRESCALE; ports clk, reset, tick), generating the mtime increment strobe.

Test Plan:
- Reset release, PRESCALE=1, no access for 10 cycles; then read 0xBFF8 → memory_valid one cycle after accept; data = cycles elapsed at accept; memory_ready low only in the valid cycle.
- Write mtime lo = 32'hFFFF_FFFF (mask all ones), then read mtime hi two cycles later → mtime hi reads 1, mtime lo has wrapped to a small value.
- Write mtimecmp hi = 0 and lo = 20 with mtime counting from 0 → timer_interrupt rises exactly when registered mtime reaches 20, one cycle after mtime crosses. Then write mtimecmp lo = 32'hFFFF_FFFF → timer_interrupt falls one cycle after the write completes.
- Write msip with data 32'h3, mask 32'h1 → software_interrupt = 1 and read of msip = 32'h1. Write data 0, mask 32'h0 → unchanged. Write data 0, mask all ones → cleared.
- Assert memory_enable continuously with reads → one memory_valid every 2 cycles, never back-to-back. Assert reset during RESPOND → memory_valid = 0 next cycle, mtime = 0, memory_ready = 1.
- PRESCALE=4: from reset, mtime reads 2 after 8 cycles. Write mtime hi in the same cycle as a tick → mtime lo is not incremented that cycle.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// request encoding, FSM states and the masked-write helper.
package clint_pkg;

  localparam logic [15:0] MSIP_OFFSET        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFFSET = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFFSET = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFFSET    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFFSET    = 16'hBFFC;

  localparam logic MEMORY_COMMAND_READ  = 1'b0;
  localparam logic MEMORY_COMMAND_WRITE = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } clint_state_t;

  function automatic logic [31:0] apply_mask(input logic [31:0] old_value,
                                             input logic [31:0] data,
                                             input logic [31:0] mask);
    return (old_value & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/clint_if.sv
// Memory request/response bus between the core (master) and the CLINT (slave).
interface clint_if;

  logic        memory_enable;
  logic        memory_command;
  logic [31:0] read_memory_address;
  logic [31:0] write_memory_address;
  logic [31:0] write_memory_data;
  logic [31:0] write_memory_mask;
  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] read_memory_data;

  modport master (
    output memory_enable, memory_command, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    input  memory_ready, memory_valid, read_memory_data
  );

  modport slave (
    input  memory_enable, memory_command, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    output memory_ready, memory_valid, read_memory_data
  );

endinterface

// File: rtl/clint_tick_divider.sv
// Free-running prescaler: strobes tick once every PRESCALE clock cycles.
module tick_divider #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip registers behind a two-state
// request/respond slave, driving the timer and software interrupt levels.
module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0200_0000,
  parameter int          PRESCALE     = 1
) (
  input  logic    clk,
  input  logic    reset,
  clint_if.slave  mem,
  output logic    timer_interrupt,
  output logic    software_interrupt
);

  clint_state_t state_q, state_d;
  logic [63:0]  mtime_q, mtime_d;
  logic [63:0]  mtimecmp_q, mtimecmp_d;
  logic         msip_q, msip_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         timer_q, timer_d;
  logic         tick;
  logic         accept, is_read, is_write, rd_hit, wr_hit;
  logic [15:0]  rd_off, wr_off;
  logic [31:0]  read_value;
  logic         unused_addr_bits;

  tick_divider #(.PRESCALE(PRESCALE)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign accept   = (state_q == IDLE) && mem.memory_enable;
  assign is_read  = accept && (mem.memory_command == MEMORY_COMMAND_READ);
  assign is_write = accept && (mem.memory_command == MEMORY_COMMAND_WRITE);
  assign rd_hit   = (mem.read_memory_address[31:16] == BASE_ADDRESS[31:16]);
  assign wr_hit   = (mem.write_memory_address[31:16] == BASE_ADDRESS[31:16]);
  assign rd_off   = {mem.read_memory_address[15:2], 2'b00};
  assign wr_off   = {mem.write_memory_address[15:2], 2'b00};
  assign unused_addr_bits = ^{mem.read_memory_address[1:0], mem.write_memory_address[1:0]};

  // Read mux samples the current registers, before any same-cycle update.
  always_comb begin
    read_value = 32'h0000_0000;
    if (rd_hit) begin
      case (rd_off)
        MSIP_OFFSET:        read_value = {31'b0, msip_q};
        MTIMECMP_LO_OFFSET: read_value = mtimecmp_q[31:0];
        MTIMECMP_HI_OFFSET: read_value = mtimecmp_q[63:32];
        MTIME_LO_OFFSET:    read_value = mtime_q[31:0];
        MTIME_HI_OFFSET:    read_value = mtime_q[63:32];
        default:            read_value = 32'h0000_0000;
      endcase
    end else begin
      read_value = 32'h0000_0000;
    end
  end

  // Register updates; a write to either mtime half suppresses that cycle's increment.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
    if (is_write && wr_hit) begin
      case (wr_off)
        MSIP_OFFSET: msip_d = (msip_q & ~mem.write_memory_mask[0]) |
                              (mem.write_memory_data[0] & mem.write_memory_mask[0]);
        MTIMECMP_LO_OFFSET: mtimecmp_d[31:0] = apply_mask(mtimecmp_q[31:0],
                              mem.write_memory_data, mem.write_memory_mask);
        MTIMECMP_HI_OFFSET: mtimecmp_d[63:32] = apply_mask(mtimecmp_q[63:32],
                              mem.write_memory_data, mem.write_memory_mask);
        MTIME_LO_OFFSET: mtime_d = {mtime_q[63:32], apply_mask(mtime_q[31:0],
                              mem.write_memory_data, mem.write_memory_mask)};
        MTIME_HI_OFFSET: mtime_d = {apply_mask(mtime_q[63:32],
                              mem.write_memory_data, mem.write_memory_mask), mtime_q[31:0]};
        default: msip_d = msip_q;
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Request FSM, read data capture and interrupt compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem.memory_enable) begin
          state_d = RESPOND;
        end else begin
          state_d = IDLE;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (is_read) begin
      rdata_d = read_value;
    end else begin
      rdata_d = 32'h0000_0000;
    end
    timer_d = (mtime_q >= mtimecmp_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mtime_q    <= 64'h0000_0000_0000_0000;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      timer_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      timer_q    <= timer_d;
    end
  end

  assign mem.memory_ready     = (state_q == IDLE);
  assign mem.memory_valid     = (state_q == RESPOND);
  assign mem.read_memory_data = rdata_q;
  assign timer_interrupt      = timer_q;
  assign software_interrupt   = msip_q;

endmodule
